fir_mac_sequencer: RTL

- Sequences one shared saturating signed fixed-point multiplier (Width bits, Presicion fraction bits) to compute one FIR output per input sample.
- Holds the sample delay line and steps through the taps one per clock, with a combinational coefficient ROM supplying each coefficient.
- Accumulates the products with symmetric saturation.
- Sits between the sample source (ADC/strobe logic) and the output register feeding the DAC path.

---
 rtl/fir_mac_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// Single-multiplier FIR sequencer: shifts one sample into the delay line per
// start, then walks the taps one per clock and accumulates with symmetric saturation.

module fir_mac_sat_add #(
    parameter int Width = 23
) (
    input  logic signed [Width-1:0] a,
    input  logic signed [Width-1:0] b,
    output logic signed [Width-1:0] y
);
    // Limits are +/-(2^(Width-1)-1); the most-negative code is never produced.
    localparam logic signed [Width:0] POS = {2'b00, {(Width-1){1'b1}}};
    localparam logic signed [Width:0] NEG = -POS;

    logic signed [Width:0] sum;

    assign sum = {a[Width-1], a} + {b[Width-1], b};

    always_comb begin
        if (sum > POS)      y = POS[Width-1:0];
        else if (sum < NEG) y = NEG[Width-1:0];
        else                y = sum[Width-1:0];
    end
endmodule

module fir_mac_sequencer #(
    parameter int Width     = 23,
    parameter int Presicion = 14,
    parameter int Taps      = 5,
    parameter int AddrW     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [Width-1:0] x_in,
    output logic [AddrW-1:0]        coef_addr,
    input  logic signed [Width-1:0] coef_data,
    output logic signed [Width-1:0] mult_a,
    output logic signed [Width-1:0] mult_b,
    input  logic signed [Width-1:0] mult_y,
    output logic signed [Width-1:0] y_out,
    output logic                    busy,
    output logic                    done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AddrW-1:0] LAST = AddrW'(Taps - 1);

    logic [1:0]                  state;
    logic [Taps-1:0][Width-1:0]  dl;
    logic [AddrW-1:0]            idx;
    logic signed [Width-1:0]     acc;
    logic signed [Width-1:0]     acc_nxt;
    logic signed [Width-1:0]     tap_word;
    logic                        in_mac;

    // Explicit select keeps the index width independent of Taps.
    always_comb begin
        tap_word = '0;
        for (int k = 0; k < Taps; k++) begin
            if (idx == AddrW'(k)) tap_word = dl[k];
        end
    end

    assign in_mac    = (state == S_MAC);
    assign coef_addr = in_mac ? idx       : '0;
    assign mult_a    = in_mac ? tap_word  : '0;
    assign mult_b    = in_mac ? coef_data : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    fir_mac_sat_add #(.Width(Width)) u_acc (
        .a (acc),
        .b (mult_y),
        .y (acc_nxt)
    );

    // y_out is loaded on the last MAC edge so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            dl    <= '0;
            acc   <= '0;
            idx   <= '0;
            y_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dl    <= {dl[Taps-2:0], x_in};
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_nxt;
                    if (idx == LAST) begin
                        y_out <= acc_nxt;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
